// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write arbiter: the address-width
// helper and the write-request record used at the default configuration.
package regfile_pkg;

    // Width of an index into n things; never less than one bit.
    function automatic int addr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_WIDTH = 32;
    localparam int DEF_N_REG = 32;
    localparam int DEF_AW    = addr_width(DEF_N_REG);

    typedef struct packed {
        logic                valid;
        logic [DEF_AW-1:0]   addr;
        logic [DEF_WIDTH-1:0] data;
    } wr_req_t;

endpackage

// File: rtl/regfile_wr_arb_rr.sv
// Round-robin search: one-hot grant to the first set request at or above
// ptr, wrapping from N-1 back to 0.
module rr_arbiter
    import regfile_pkg::*;
#(
    parameter  int N  = 4,
    localparam int PW = addr_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant
);

    // Walking from the farthest candidate back to ptr lets the closest hit win.
    always_comb begin
        int idx;
        grant = '0;
        idx   = 0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % N;
            if (req[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_wr_arb.sv
// Round-robin write arbiter in front of a register file with a one-cycle
// registered write stage. Define REGFILE_WR_ARB_ZERO_REG_EN to drop writes to register 0.
module regfile_wr_arb
    import regfile_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int N_REG = 32,
    parameter  int N_REQ = 4,
    localparam int AW    = addr_width(N_REG),
    localparam int PW    = addr_width(N_REQ)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [N_REQ-1:0]               req_valid,
    output logic [N_REQ-1:0]               req_ready,
    input  logic [N_REQ-1:0][AW-1:0]       req_addr,
    input  logic [N_REQ-1:0][WIDTH-1:0]    req_data,
    input  logic                           stall,
    output logic                           wen,
    output logic [AW-1:0]                  waddr,
    output logic [WIDTH-1:0]               wdata,
    output logic [N_REG-1:0]               pending
);

    logic [PW-1:0]    ptr;
    logic [PW-1:0]    ptr_next;
    logic [N_REQ-1:0] grant;
    logic [PW-1:0]    gidx;
    logic [AW-1:0]    sel_addr;
    logic [WIDTH-1:0] sel_data;
    logic             xfer;

    rr_arbiter #(.N(N_REQ)) u_rr (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (grant)
    );

    // Grants are suppressed during reset so nothing can transfer on that edge.
    assign req_ready = (rst_n && !stall) ? grant : '0;
    assign xfer      = |req_ready;

    always_comb begin
        gidx     = '0;
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (req_ready[i]) begin
                gidx     = PW'(i);
                sel_addr = req_addr[i];
                sel_data = req_data[i];
            end
        end
    end

    assign ptr_next = (gidx == PW'(N_REQ - 1)) ? '0 : gidx + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr   <= '0;
            wen   <= 1'b0;
            waddr <= '0;
            wdata <= '0;
        end else begin
            if (xfer) begin
                ptr <= ptr_next;
            end
`ifdef REGFILE_WR_ARB_ZERO_REG_EN
            // Register 0 is hardwired: accept the request but issue no write.
            wen <= xfer && (sel_addr != '0);
            if (xfer && (sel_addr != '0)) begin
                waddr <= sel_addr;
                wdata <= sel_data;
            end
`else
            wen <= xfer;
            if (xfer) begin
                waddr <= sel_addr;
                wdata <= sel_data;
            end
`endif
        end
    end

    always_comb begin
        pending = '0;
        if (wen) begin
            pending[waddr] = 1'b1;
        end
    end

endmodule

// File: tb/tb_regfile_wr_arb.sv
// Self-checking bench for regfile_wr_arb: a cycle-level reference model plus
// directed vectors with hand-computed expectations.
module tb_regfile_wr_arb;
    import regfile_pkg::*;

    localparam int NQ = 4;
`ifdef REGFILE_WR_ARB_ZERO_REG_EN
    localparam bit ZERO_EN = 1'b1;
`else
    localparam bit ZERO_EN = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 stall = 1'b0;
    logic [NQ-1:0]        req_valid = '0;
    logic [NQ-1:0]        req_ready;
    logic [NQ-1:0][4:0]   req_addr;
    logic [NQ-1:0][31:0]  req_data;
    logic                 wen;
    logic [4:0]           waddr;
    logic [31:0]          wdata;
    logic [31:0]          pending;

    int n_checks = 0;
    int n_fail   = 0;

    regfile_wr_arb dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .stall     (stall),
        .wen       (wen),
        .waddr     (waddr),
        .wdata     (wdata),
        .pending   (pending)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic [NQ-1:0] v, input logic s);
        req_valid = v;
        stall     = s;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Reference model: who wins, where the pointer goes, what gets written.
    int      m_ptr;
    wr_req_t m_stage;

    function automatic int winner(input logic [NQ-1:0] v, input int p);
        for (int k = 0; k < NQ; k++) begin
            if (v[(p + k) % NQ]) return (p + k) % NQ;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ptr   = 0;
            m_stage = '0;
        end else begin
            int w;
            w = stall ? -1 : winner(req_valid, m_ptr);
            if (w >= 0) begin
                m_ptr = (w + 1) % NQ;
                if (ZERO_EN && req_addr[w] == 5'd0)
                    m_stage.valid = 1'b0;
                else
                    m_stage = '{1'b1, req_addr[w], req_data[w]};
            end else begin
                m_stage.valid = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        logic [NQ-1:0] er;
        logic [31:0]   ep;
        int            w;
        w  = winner(req_valid, m_ptr);
        er = (rst_n && !stall && w >= 0) ? (NQ'(1) << w) : '0;
        ep = m_stage.valid ? (32'd1 << m_stage.addr) : 32'd0;
        checkOutput("cmp_req_ready", 64'(req_ready), 64'(er));
        checkOutput("cmp_wen",       64'(wen),       64'(m_stage.valid));
        checkOutput("cmp_waddr",     64'(waddr),     64'(m_stage.addr));
        checkOutput("cmp_wdata",     64'(wdata),     64'(m_stage.data));
        checkOutput("cmp_pending",   64'(pending),   64'(ep));
    end

    typedef struct {
        logic [NQ-1:0] v;
        logic          s;
    } vec_t;

    initial begin
        logic [NQ-1:0] rr_seq [4];
        vec_t          tbl [10];

        rr_seq = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
        tbl = '{'{4'b1010, 1'b0}, '{4'b1010, 1'b0}, '{4'b0110, 1'b1}, '{4'b0001, 1'b0},
                '{4'b1001, 1'b0}, '{4'b1111, 1'b1}, '{4'b1000, 1'b0}, '{4'b0000, 1'b0},
                '{4'b0111, 1'b0}, '{4'b1101, 1'b0}};
        for (int i = 0; i < NQ; i++) begin
            req_addr[i] = 5'(3 * i + 1);
            req_data[i] = 32'hA000_0000 + 32'(i);
        end

        // Reset with every requester asking
        applyStimulus(4'b1111, 1'b0);
        repeat (2) tick();
        checkOutput("rst_ready",   64'(req_ready), 64'h0);
        checkOutput("rst_wen",     64'(wen),       64'h0);
        checkOutput("rst_pending", 64'(pending),   64'h0);

        rst_n = 1'b1;
        #1;
        checkOutput("rr_first", 64'(req_ready), 64'h1);

        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("rr_seq", 64'(req_ready), 64'(rr_seq[i]));
            if (i == 0) begin
                checkOutput("rr_waddr0",   64'(waddr),   64'd1);
                checkOutput("rr_wdata0",   64'(wdata),   64'hA000_0000);
                checkOutput("rr_pending0", 64'(pending), 64'h2);
            end
        end

        // Fifth grant goes back to requester 0, then stall requester 2
        tick();
        applyStimulus(4'b0100, 1'b1);
        checkOutput("rr_wen5",   64'(wen),   64'h1);
        checkOutput("rr_waddr5", 64'(waddr), 64'd1);
        for (int i = 0; i < 3; i++) begin
            checkOutput("stall_ready", 64'(req_ready), 64'h0);
            tick();
            checkOutput("stall_wen", 64'(wen), 64'h0);
        end
        applyStimulus(4'b0100, 1'b0);
        checkOutput("unstall_ready", 64'(req_ready), 64'b0100);
        tick();
        checkOutput("unstall_wen",   64'(wen),   64'h1);
        checkOutput("unstall_waddr", 64'(waddr), 64'd7);

        // Pointer now 3: wrap to requester 0, pointer moves to 1
        applyStimulus(4'b0011, 1'b0);
        checkOutput("wrap_ready", 64'(req_ready), 64'b0001);
        tick();
        checkOutput("wrap_next", 64'(req_ready), 64'b0010);
        applyStimulus(4'b0000, 1'b0);
        checkOutput("wrap_waddr", 64'(waddr), 64'd1);

        // Write to register 0
        req_addr[1] = 5'd0;
        req_data[1] = 32'hDEAD_BEEF;
        applyStimulus(4'b0010, 1'b0);
        checkOutput("zero_ready", 64'(req_ready), 64'b0010);
        tick();
        applyStimulus(4'b0000, 1'b0);
        if (ZERO_EN) begin
            checkOutput("zero_wen",     64'(wen),     64'h0);
            checkOutput("zero_pending", 64'(pending), 64'h0);
        end else begin
            checkOutput("zero_wen",     64'(wen),     64'h1);
            checkOutput("zero_waddr",   64'(waddr),   64'd0);
            checkOutput("zero_wdata",   64'(wdata),   64'hDEAD_BEEF);
            checkOutput("zero_pending", 64'(pending), 64'h1);
        end
        tick();
        checkOutput("idle_wen", 64'(wen), 64'h0);
        req_addr[1] = 5'd4;
        req_data[1] = 32'hA000_0001;

        // Asynchronous reset while a write is being presented
        applyStimulus(4'b1111, 1'b0);
        checkOutput("mid_ready", 64'(req_ready), 64'b0100);
        tick();
        checkOutput("mid_wen_before", 64'(wen), 64'h1);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_wen_after", 64'(wen),       64'h0);
        checkOutput("mid_pending",   64'(pending),   64'h0);
        checkOutput("mid_ready_rst", 64'(req_ready), 64'h0);
        tick();
        rst_n = 1'b1;
        #1;
        checkOutput("post_rst_ready", 64'(req_ready), 64'b0001);
        tick();
        checkOutput("post_rst_wen",   64'(wen),   64'h1);
        checkOutput("post_rst_waddr", 64'(waddr), 64'd1);

        // Mixed patterns checked by the model each cycle
        foreach (tbl[i]) begin
            for (int j = 0; j < NQ; j++) begin
                req_data[j] = $urandom;
                req_addr[j] = 5'($urandom_range(1, 31));
            end
            applyStimulus(tbl[i].v, tbl[i].s);
            tick();
        end
        applyStimulus(4'b0000, 1'b0);
        repeat (2) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_wr_arb.md
REGFILE_WR_ARB -- requirements
Module: regfile_wr_arb

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the data width of every write request and of the write output.
REQ-002 Parameter N_REG, default 32, SHALL set the number of target registers; AW = $clog2(N_REG).
REQ-003 Parameter N_REQ, default 4, SHALL set the number of write requesters.
REQ-004 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-005 rst_n  input  1  SHALL be the reset: asynchronous assertion, active-low.
REQ-006 req_valid  input  [N_REQ-1:0]  SHALL mark a write request from each requester.
REQ-007 req_ready  output  [N_REQ-1:0]  SHALL be the per-requester grant, one-hot or zero.
REQ-008 req_addr  input  [N_REQ-1:0][AW-1:0]  SHALL give the target register of each request.
REQ-009 req_data  input  [N_REQ-1:0][WIDTH-1:0]  SHALL give the write data of each request.
REQ-010 stall  input  1  SHALL block all grants while high.
REQ-011 wen  output  1  SHALL be the registered write enable to the register file.
REQ-012 waddr  output  AW  SHALL be the registered write address.
REQ-013 wdata  output  WIDTH  SHALL be the registered write data.
REQ-014 pending  output  [N_REG-1:0]  SHALL be the one-hot decode of waddr when wen=1, and all zeros otherwise.

Function
REQ-015 A transfer SHALL occur on requester i when req_valid[i] and req_ready[i] are both high at a rising edge.
REQ-016 req_ready SHALL be combinational and SHALL grant at most one valid requester.
REQ-017 The grant SHALL go to the first valid requester found searching upward from pointer ptr, wrapping from N_REQ-1 to 0.
REQ-018 req_ready SHALL be all zeros when stall=1 or when no req_valid bit is set.
REQ-019 After a transfer from requester g, ptr SHALL become (g+1) mod N_REQ; otherwise ptr SHALL hold.
REQ-020 A transfer at edge k SHALL present wen=1 with the request's waddr/wdata during cycle k+1, for exactly one cycle (fixed latency 1).
REQ-021 With no transfer at edge k, wen SHALL be 0 in cycle k+1, and waddr/wdata SHALL hold their previous values.
REQ-022 The output stage SHALL never backpressure: a transfer SHALL be possible every cycle, giving 1 write/cycle sustained throughput.
REQ-023 A requester SHALL be granted within N_REQ non-stalled cycles of raising req_valid and holding it (starvation-free).
REQ-024 A request held while not granted SHALL NOT be modified by the block; requesters keep addr/data stable until ready.
REQ-025 Consecutive transfers to the same address SHALL all be issued in grant order; no coalescing.

Reset
REQ-026 While rst_n=0: wen=0, waddr=0, wdata=0, ptr=0, pending=0, and req_ready SHALL be forced to all zeros.
REQ-027 Reset mid-transfer SHALL discard any output-stage write (wen drops immediately) and any transfer at that edge.
REQ-028 The first grant after rst_n rises SHALL start its search from requester 0.

Configuration
REQ-029 Macro REGFILE_WR_ARB_ZERO_REG_EN defined: a transfer with address 0 SHALL be accepted normally, advancing ptr, but SHALL produce wen=0 and pending=0 in the next cycle.
REQ-030 Macro REGFILE_WR_ARB_ZERO_REG_EN undefined: address 0 SHALL be treated like any other address.

Structure
REQ-031 A shared package regfile_pkg SHALL hold the address-width helper function and the write-request struct (valid, addr, data).
REQ-032 The round-robin search SHALL be a sub-module rr_arbiter (inputs: request vector, pointer; output: one-hot grant).

Verification
REQ-033 Reset: with rst_n=0 and all req_valid=1 -> req_ready=0, wen=0, pending=0.
REQ-034 Round robin: all 4 requesters valid continuously from reset -> grants 0,1,2,3,0; wen=1 every cycle with matching addr/data one cycle later.
REQ-035 Stall: req_valid=4'b0100 with stall=1 for 3 cycles -> req_ready=0 and wen=0 throughout; at stall=0, grant requester 2 and wen=1 on the next cycle.
REQ-036 Wrap: ptr=3 with req_valid=4'b0011 -> grant requester 0, then ptr=1.
REQ-037 Zero reg with macro defined: request addr=0, data=0xDEADBEEF -> accepted, wen stays 0; with macro undefined -> wen=1, waddr=0, pending[0]=1.
REQ-038 Mid-reset: assert rst_n=0 asynchronously while wen=1 -> wen=0 immediately; after release, first grant is from requester 0.
